trivium_stream_core: RTL and testbench



---
 rtl/trivium_stream_core.sv | 183 ++++++++++++++++++
 tb/tb_trivium_stream_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_stream_core.sv
// Trivium stream-cipher engine: byte-wide key/IV config, warm-up, then XORs
// keystream onto DATA_W-bit words. Optional word budget: TRIVIUM_KS_LIMIT_EN.

module trivium_round (
  input  logic [287:0] s_in,
  output logic [287:0] s_out,
  output logic         z
);
  // s_in[i-1] holds Trivium bit s_i
  logic t1, t2, t3, t1f, t2f, t3f;

  assign t1  = s_in[65]  ^ s_in[92];
  assign t2  = s_in[161] ^ s_in[176];
  assign t3  = s_in[242] ^ s_in[287];
  assign z   = t1 ^ t2 ^ t3;
  assign t1f = t1 ^ (s_in[90]  & s_in[91])  ^ s_in[170];
  assign t2f = t2 ^ (s_in[174] & s_in[175]) ^ s_in[263];
  assign t3f = t3 ^ (s_in[285] & s_in[286]) ^ s_in[68];
  assign s_out = {s_in[286:177], t2f, s_in[175:93], t1f, s_in[91:0], t3f};
endmodule

module trivium_stream_core #(
  parameter int DATA_W        = 8,
  parameter int BPC           = 1,
  parameter int WARMUP_ROUNDS = 1152,
  parameter int KS_LIMIT      = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              exhausted
);
  localparam int WU_CYC  = WARMUP_ROUNDS / BPC;
  localparam int GEN_CYC = DATA_W / BPC;
  localparam int MAX_CYC = (WU_CYC > GEN_CYC) ? WU_CYC : GEN_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {IDLE, WARMUP, RUN, GEN, HOLD, EXHAUSTED} state_t;

  state_t              state, state_nxt;
  logic [79:0]         key, iv, key_nxt, iv_nxt;
  logic [287:0]        cs;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   word, word_nxt;
  logic                ld, adv, cap, gen, fin;

  logic [BPC:0][287:0] chain;
  logic [BPC-1:0]      zv;

  // Config bytes; a write coincident with start feeds that same load
  always_comb begin
    key_nxt = key;
    iv_nxt  = iv;
    if (cfg_we) begin
      for (int b = 0; b < 10; b++) begin
        if (cfg_addr == 5'(b))      key_nxt[8*b +: 8] = cfg_wdata;
        if (cfg_addr == 5'(b + 10)) iv_nxt[8*b +: 8]  = cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key <= '0;
      iv  <= '0;
    end else begin
      key <= key_nxt;
      iv  <= iv_nxt;
    end
  end

  // BPC unrolled rounds; zv[0] is the earliest keystream bit of the clock
  assign chain[0] = cs;
  generate
    for (genvar i = 0; i < BPC; i++) begin : g_rnd
      trivium_round u_rnd (.s_in(chain[i]), .s_out(chain[i+1]), .z(zv[i]));
    end
    // Rotate right by BPC while XORing the leaving chunk, so after GEN_CYC
    // steps keystream bit k has landed in word bit k
    if (DATA_W == BPC) begin : g_word_full
      assign word_nxt = word ^ zv;
    end else begin : g_word_rot
      assign word_nxt = {word[BPC-1:0] ^ zv, word[DATA_W-1:BPC]};
    end
  endgenerate

`ifdef TRIVIUM_KS_LIMIT_EN
  logic [31:0] words;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     words <= '0;
    else if (start)                                 words <= '0;
    else if (state == HOLD && out_ready)            words <= words + 32'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    ld  = 1'b0;
    adv = 1'b0;
    cap = 1'b0;
    gen = 1'b0;
    fin = 1'b0;
    if (start) begin
      state_nxt = WARMUP;
      ld        = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        WARMUP: begin
          adv = 1'b1;
          if (cnt == '0) state_nxt = RUN;
        end
        RUN: if (in_valid) begin
          cap       = 1'b1;
          state_nxt = GEN;
        end
        GEN: begin
          adv = 1'b1;
          gen = 1'b1;
          if (cnt == '0) begin
            fin       = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: if (out_ready) begin
          state_nxt = RUN;
`ifdef TRIVIUM_KS_LIMIT_EN
          if (words + 32'd1 == 32'(KS_LIMIT)) state_nxt = EXHAUSTED;
`endif
        end
`ifdef TRIVIUM_KS_LIMIT_EN
        EXHAUSTED: ;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs        <= '0;
      cnt       <= '0;
      word      <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld)       cs <= {3'b111, 112'b0, iv_nxt, 13'b0, key_nxt};
      else if (adv) cs <= chain[BPC];
      if (ld)                    cnt <= CNT_W'(WU_CYC - 1);
      else if (cap)              cnt <= CNT_W'(GEN_CYC - 1);
      else if (adv && cnt != '0) cnt <= cnt - 1'b1;
      if (cap)      word <= in_data;
      else if (gen) word <= word_nxt;
      if (fin)      out_data <= word_nxt;
      busy      <= (state_nxt == WARMUP);
      in_ready  <= (state_nxt == RUN);
      out_valid <= (state_nxt == HOLD);
    end
  end

`ifdef TRIVIUM_KS_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exhausted <= 1'b0;
    else        exhausted <= (state_nxt == EXHAUSTED);
  end
`else
  assign exhausted = 1'b0;
`endif
endmodule

// File: tb/tb_trivium_stream_core.sv
// Directed bench for trivium_stream_core: 8-bit/1-bpc core plus a 64-bit/8-bpc
// core sharing config and start, checked against a bit-serial Trivium model.

module tb_trivium_stream_core;
  logic        clk, rst_n, cfg_we, start;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        a_busy, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_exh;
  logic [7:0]  a_in_data, a_out_data;
  logic        b_busy, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_exh;
  logic [63:0] b_in_data, b_out_data;

  int ntests = 0;
  int nfail  = 0;

  trivium_stream_core u_a (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(a_busy), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready), .exhausted(a_exh));

  trivium_stream_core #(.DATA_W(64), .BPC(8), .KS_LIMIT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(b_busy), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .exhausted(b_exh));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference, 1-based exactly as the algorithm is written
  logic m [1:288];

  task automatic m_step(output logic z);
    logic t1, t2, t3;
    t1 = m[66] ^ m[93];
    t2 = m[162] ^ m[177];
    t3 = m[243] ^ m[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m[91] & m[92]) ^ m[171];
    t2 = t2 ^ (m[175] & m[176]) ^ m[264];
    t3 = t3 ^ (m[286] & m[287]) ^ m[69];
    for (int i = 288; i > 178; i--) m[i] = m[i-1];
    m[178] = t2;
    for (int i = 177; i > 94; i--) m[i] = m[i-1];
    m[94] = t1;
    for (int i = 93; i > 1; i--) m[i] = m[i-1];
    m[1] = t3;
  endtask

  task automatic m_init(input logic [79:0] k, input logic [79:0] v);
    logic z;
    for (int i = 1; i <= 288; i++) m[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      m[i]      = k[i-1];
      m[93 + i] = v[i-1];
    end
    m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
    for (int i = 0; i < 1152; i++) m_step(z);
  endtask

  task automatic m_bits(input int n, output logic [63:0] ks);
    logic z;
    ks = '0;
    for (int i = 0; i < n; i++) begin
      m_step(z);
      ks[i] = z;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Writes all 20 config bytes (plus one to an ignored address); optionally
  // raises start together with the last byte
  task automatic load_key(input logic [79:0] k, input logic [79:0] v, input bit with_start);
    cfg_we = 1'b1; cfg_addr = 5'd31; cfg_wdata = 8'hFF;
    tick();
    for (int a = 0; a < 20; a++) begin
      cfg_addr  = 5'(a);
      cfg_wdata = (a < 10) ? k[8*a +: 8] : v[8*(a-10) +: 8];
      start     = with_start && (a == 19);
      tick();
    end
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_busy(output int na, output int nb, output bit saw_ov);
    na = 0; nb = 0; saw_ov = 1'b0;
    for (int g = 0; g < 2000; g++) begin
      if (!a_busy && !b_busy) break;
      if (a_busy) na++;
      if (b_busy) nb++;
      if (a_out_valid) saw_ov = 1'b1;
      tick();
    end
  endtask

  task automatic xa(input logic [7:0] d, input int stall, output logic [7:0] o,
                    output int lat, output bit unstable, output bit rdy_seen);
    int g;
    g = 0; unstable = 1'b0; rdy_seen = 1'b0;
    while (!a_in_ready && g < 3000) begin tick(); g++; end
    a_in_data = d; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 200) begin tick(); lat++; end
    o = a_out_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (a_out_data !== o || !a_out_valid) unstable = 1'b1;
      if (a_in_ready) rdy_seen = 1'b1;
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic xb(input logic [63:0] d, output logic [63:0] o, output int lat);
    int g;
    g = 0;
    while (!b_in_ready && g < 3000) begin tick(); g++; end
    b_in_data = d; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 200) begin tick(); lat++; end
    o = b_out_data;
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  logic [63:0] ks, gold, ob;
  logic [7:0]  o;
  logic [7:0]  pt [4];
  logic [7:0]  ct [4];
  int          na, nb, lat;
  bit          sov, unst, rdy;
  localparam logic [79:0] K1  = 80'h09080706050403020100;
  localparam logic [79:0] IV1 = 80'h00000000000000000076;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;
    repeat (3) tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_exhausted", a_exh, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_in_ready", a_in_ready, 0);

    // Golden keystream, key=0 IV=0, both widths
    pulse_start();
    wait_busy(na, nb, sov);
    chk("warm_a", na, 1152);
    chk("warm_b", nb, 144);
    chk("ready_after_warm", a_in_ready, 1);
    m_init('0, '0);
    m_bits(64, gold);
    for (int i = 0; i < 8; i++) begin
      xa(8'h00, 0, o, lat, unst, rdy);
      chk($sformatf("gold_a%0d", i), o, gold[8*i +: 8]);
    end
    chk("gold_a_lat", lat, 8);
    xb('0, ob, lat);
    chk("gold_b", ob, gold);
    chk("gold_b_lat", lat, 8);

    // Round trip; last config byte written in the same cycle as start
    load_key(K1, IV1, 1'b1);
    wait_busy(na, nb, sov);
    chk("warm_rt", na, 1152);
    m_init(K1, IV1);
    m_bits(32, ks);
    for (int i = 0; i < 4; i++) begin
      xa(pt[i], 0, o, lat, unst, rdy);
      ct[i] = o;
      chk($sformatf("enc%0d", i), o, pt[i] ^ ks[8*i +: 8]);
      chk($sformatf("enc_lat%0d", i), lat, 8);
    end
    pulse_start();
    wait_busy(na, nb, sov);
    for (int i = 0; i < 4; i++) begin
      xa(ct[i], 0, o, lat, unst, rdy);
      chk($sformatf("dec%0d", i), o, pt[i]);
    end

    // Back-pressure: 20-cycle stall on the first word
    pulse_start();
    wait_busy(na, nb, sov);
    xa(pt[0], 20, o, lat, unst, rdy);
    chk("bp_word0", o, ct[0]);
    chk("bp_stable", unst, 0);
    chk("bp_no_ready", rdy, 0);
    xa(pt[1], 0, o, lat, unst, rdy);
    chk("bp_word1", o, ct[1]);

    // Restart during GEN
    a_in_data = pt[2]; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    pulse_start();
    chk("restart_ov_drop", a_out_valid, 0);
    wait_busy(na, nb, sov);
    chk("restart_warm", na, 1152);
    chk("restart_no_ov", sov, 0);
    xa(pt[0], 0, o, lat, unst, rdy);
    chk("restart_word", o, ct[0]);

    // Asynchronous reset in the middle of GEN
    a_in_data = pt[1]; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_data", a_out_data, 0);
    chk("arst_out_valid", a_out_valid, 0);
    chk("arst_busy", a_busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("arst_in_ready", a_in_ready, 0);

    // Word budget on the 64-bit core (limit 4 when enabled)
    pulse_start();
    wait_busy(na, nb, sov);
    xb('0, ob, lat);
    chk("budget_w0", ob, gold);
    for (int i = 1; i < 4; i++) xb(64'(i), ob, lat);
    tick();
`ifdef TRIVIUM_KS_LIMIT_EN
    chk("budget_exh", b_exh, 1);
    chk("budget_no_ready", b_in_ready, 0);
    b_in_valid = 1'b1;
    repeat (10) tick();
    chk("budget_refused", b_out_valid, 0);
    b_in_valid = 1'b0;
    pulse_start();
    chk("budget_cleared", b_exh, 0);
`else
    chk("budget_no_exh", b_exh, 0);
    chk("budget_ready", b_in_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
